// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: valid/ready byte handshake feeding the UART transmit FIFO
interface uart_tx_fifo_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    modport master (output in_data, in_valid, input in_ready);
    modport slave (input in_data, in_valid, output in_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART transmitter with enable freeze
module uart_tx_fifo #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_ena,
    uart_tx_fifo_if.slave    s_in,
    output logic             o_tx,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_fifo_count
);
    localparam int AW = CNT_W - 1;
    localparam int BW = $clog2(CLK_DIV);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t           r_state;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr, r_rd;
    logic [CNT_W-1:0] r_count;
    logic [BW-1:0]    r_baud;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             r_tx, r_busy;
    logic             w_push, w_pop, w_wrap;
    assign w_wrap         = r_baud == BW'(CLK_DIV - 1);
    assign s_in.in_ready  = (r_count != CNT_W'(FIFO_DEPTH)) && !rst;
    assign w_push         = s_in.in_valid && s_in.in_ready;
    assign w_pop          = i_ena && (r_count != '0) && (r_state == IDLE || (r_state == STOP && w_wrap));
    assign o_tx           = r_tx;
    assign o_busy         = r_busy;
    assign o_fifo_count   = r_count;
    // FIFO storage: written on every accepted byte, never reset
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= s_in.in_data;
    end
    // FIFO pointers and occupancy; a pop and push together leave the count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end
    // Transmit FSM; outputs follow the state one cycle later and everything freezes while ena is low
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else if (i_ena) begin
            r_tx   <= (r_state == START) ? 1'b0 : (r_state == DATA) ? r_shift[0] : 1'b1;
            r_busy <= r_state != IDLE;
            r_baud <= (r_state == IDLE || w_wrap) ? '0 : r_baud + 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd];
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_wrap) begin
                        r_bit   <= '0;
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_wrap) begin
                        r_shift <= r_shift >> 1;
                        r_bit   <= r_bit + 1'b1;
                        if (r_bit == 3'd7) r_state <= STOP;
                    end
                end
                STOP: begin
                    if (w_wrap) begin
                        if (w_pop) begin
                            r_shift <= r_mem[r_rd];
                            r_state <= START;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench decoding UART frames and comparing against queued bytes
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic       tx, busy;
    logic [2:0] fifo_count;
    uart_tx_fifo_if bus();
    uart_tx_fifo #(.CLK_DIV(4), .FIFO_DEPTH(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .i_ena(ena), .s_in(bus),
        .o_tx(tx), .o_busy(busy), .o_fifo_count(fifo_count)
    );
    always #5 clk = ~clk;
    int n_checks = 0, n_pass = 0;
    logic [7:0] exp_q[$];
    int cyc = 0;
    logic prev_ena = 1'b1, prev_rst = 1'b1;
    bit in_frame = 0;
    int eff = 0, len = 0, last_len = 0, last_start = 0, prev_start = 0, n_frames = 0;
    logic [9:0] raw = '0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask
    // Cycle counter plus the ena/rst values seen by the DUT at each edge
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        prev_ena <= ena;
        prev_rst <= rst;
    end
    // Frame decoder: counts only cycles where the DUT advanced, samples mid-bit, checks against the queue
    always @(negedge clk) begin
        if (prev_rst) begin
            in_frame = 0;
        end else if (!in_frame) begin
            if (tx === 1'b0) begin
                in_frame   = 1;
                eff        = 0;
                len        = 1;
                raw        = '0;
                prev_start = last_start;
                last_start = cyc;
            end
        end else begin
            len++;
            if (prev_ena) begin
                eff++;
                if (eff % 4 == 2) raw[eff/4] = tx;
                if (eff == 39) begin
                    in_frame = 0;
                    n_frames++;
                    last_len = len;
                    check("framing", {raw[9], raw[0]}, 2'b10);
                    if (exp_q.size() == 0) check("spurious_frame", raw[8:1], 32'hFFFF_FFFF);
                    else check("frame_data", raw[8:1], exp_q.pop_front());
                end
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic push(input logic [7:0] b);
        bit acc = 0;
        int n = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus.in_ready;
            n++;
            tick();
        end
        bus.in_valid = 1'b0;
        if (acc) exp_q.push_back(b);
        else check("push_timeout", 0, 1);
    endtask
    task automatic wait_start();
        bit seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = (tx === 1'b0);
        end
        check("start_seen", seen, 1);
    endtask
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 100 && busy !== 1'b1; i++) @(negedge clk);
        while (busy === 1'b1 && n < 500) begin
            n++;
            @(negedge clk);
        end
    endtask
    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            done = !busy && fifo_count == 0 && !in_frame && exp_q.size() == 0;
        end
        check("idle_reached", done, 1);
    endtask
    initial begin
        int n, nf, bad;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ready", bus.in_ready, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", bus.in_ready, 1);
        tick();
        // 1: single byte latency, frame and busy length
        push(8'h55);
        @(negedge clk);
        check("lat_e0_tx", tx, 1);
        @(negedge clk);
        check("lat_e1_tx", tx, 1);
        @(negedge clk);
        check("lat_e2_tx", tx, 0);
        check("lat_e2_busy", busy, 1);
        count_busy(n);
        check("busy_len_1", n, 40);
        wait_idle();
        check("frame_len_1", last_len, 40);
        tick();
        // 2: fill while frozen, refuse a fifth byte, then drain in order
        ena = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            push(8'(i));
            @(negedge clk);
            check("fill_count", fifo_count, i);
            tick();
        end
        bus.in_data  = 8'h05;
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("full_ready", bus.in_ready, 0);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("full_count", fifo_count, 4);
        tick();
        nf  = n_frames;
        ena = 1'b1;
        wait_idle();
        check("drain_frames", n_frames - nf, 4);
        tick();
        // 3: back-to-back frames with no idle gap
        push(8'hA5);
        push(8'h3C);
        count_busy(n);
        check("busy_len_2", n, 80);
        wait_idle();
        check("frame_gap", last_start - prev_start, 40);
        tick();
        // 4: freeze for 10 cycles during data bit 3
        push(8'hFF);
        wait_start();
        repeat (17) @(posedge clk);
        #1;
        ena = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (tx !== 1'b1) bad++;
            tick();
        end
        ena = 1'b1;
        check("ena_hold", bad, 0);
        wait_idle();
        check("frame_len_freeze", last_len, 50);
        tick();
        // 5: reset mid-frame aborts and flushes
        push(8'h12);
        push(8'h34);
        push(8'h56);
        wait_start();
        repeat (10) tick();
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("abort_tx", tx, 1);
        check("abort_busy", busy, 0);
        check("abort_count", fifo_count, 0);
        nf  = n_frames;
        bad = 0;
        repeat (150) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("abort_quiet", bad, 0);
        check("abort_frames", n_frames - nf, 0);
        tick();
        // 6: full FIFO refuses a push in the same cycle as a pop
        ena = 1'b0;
        for (int i = 1; i <= 4; i++) push(8'(i * 17));
        ena          = 1'b1;
        bus.in_data  = 8'h99;
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("pop_full_ready", bus.in_ready, 0);
        check("pop_full_count", fifo_count, 4);
        tick();
        @(negedge clk);
        check("pop_count_3", fifo_count, 3);
        check("pop_ready_1", bus.in_ready, 1);
        tick();
        exp_q.push_back(8'h99);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("repush_count", fifo_count, 4);
        wait_idle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
